// File: rtl/bmp_copy_engine.sv
// ROM-to-RAM byte copy engine for BMP images: streams one byte per clock through a
// ROM_LAT-deep read pipeline, optionally skipping the header and inverting pixel bytes.
//
// state | meaning
// IDLE  | waiting for in_valid; address registers hold their last values
// RUN   | one ROM read per cycle until length reads are issued
// DRAIN | waiting for in-flight reads to be written to RAM
// DONE  | one-cycle done pulse, then back to IDLE
module bmp_copy_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 20,
    parameter int HDR_BYTES  = 54,
    parameter int ROM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] ROM_out,
    output logic                  ROM_ren,
    output logic [ADDR_WIDTH-1:0] ROM_addr,
    output logic                  RAM_ren,
    output logic                  RAM_wen,
    output logic [ADDR_WIDTH-1:0] RAM_addr,
    output logic [DATA_WIDTH-1:0] RAM_in,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_WIDTH:0]   HDR_IDX  = (ADDR_WIDTH+1)'(HDR_BYTES);
    localparam logic [ADDR_WIDTH-1:0] HDR_OFF  = ADDR_WIDTH'(HDR_BYTES);
    localparam logic [ADDR_WIDTH:0]   ONE_IDX  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR = ADDR_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [ADDR_WIDTH:0]     rd_cnt_q, rd_cnt_d;
    logic [1:0]              mode_q, mode_d;
    logic                    ren_q, ren_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [ROM_LAT-1:0]      vld_q, vld_d;
    logic [ROM_LAT-1:0]      pix_q, pix_d;
    logic [ADDR_WIDTH-1:0]   waddr_q [ROM_LAT];
    logic [ADDR_WIDTH-1:0]   waddr_d [ROM_LAT];
    logic [DATA_WIDTH-1:0]   ram_in_q, ram_in_d;
    logic [ADDR_WIDTH:0]     rd_next;
    logic [ADDR_WIDTH-1:0]   rd_start;
    logic [ROM_LAT-1:0]      pend;

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        dst_d      = dst_q;
        len_d      = len_q;
        rd_cnt_d   = rd_cnt_q;
        mode_d     = mode_q;
        ren_d      = ren_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pix_d      = pix_q;
        waddr_d    = waddr_q;
        rd_next    = rd_cnt_q + ONE_IDX;
        rd_start   = mode[1] ? src_base + HDR_OFF : src_base;
        pend       = vld_q;
        pend[ROM_LAT-1] = 1'b0;

        // Stage 0 captures the write address and pixel class of the read issued this cycle.
        vld_d[0] = ren_q;
        if (ren_q) begin
            pix_d[0]   = mode_q[1] || (rd_cnt_q >= HDR_IDX);
            waddr_d[0] = dst_q + rd_cnt_q[ADDR_WIDTH-1:0];
        end
        for (int i = 1; i < ROM_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
                pix_d[i]   = pix_q[i-1];
                waddr_d[i] = waddr_q[i-1];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dst_d    = dst_base;
                    len_d    = length;
                    mode_d   = mode;
                    rd_cnt_d = '0;
                    busy_d   = 1'b1;
                    if (length == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_RUN;
                        ren_d      = 1'b1;
                        rom_addr_d = rd_start;
                    end
                end
            end
            S_RUN: begin
                if (rd_next == len_q) begin
                    ren_d   = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    rd_cnt_d   = rd_next;
                    rom_addr_d = rom_addr_q + ONE_ADDR;
                end
            end
            S_DRAIN: begin
                // Only the output stage may still be occupied: that is the final write.
                if (pend == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // ROM data is only valid in the write cycle, so the write data is a mux over a hold register.
        if (vld_q[ROM_LAT-1]) begin
            ram_in_d = (mode_q[0] && pix_q[ROM_LAT-1]) ? ~ROM_out : ROM_out;
        end else begin
            ram_in_d = ram_in_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            mode_q     <= '0;
            ren_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vld_q      <= '0;
            pix_q      <= '0;
            ram_in_q   <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                waddr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            mode_q     <= mode_d;
            ren_q      <= ren_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            vld_q      <= vld_d;
            pix_q      <= pix_d;
            ram_in_q   <= ram_in_d;
            waddr_q    <= waddr_d;
        end
    end

    assign ROM_ren  = ren_q;
    assign ROM_addr = rom_addr_q;
    assign RAM_ren  = 1'b0;
    assign RAM_wen  = vld_q[ROM_LAT-1];
    assign RAM_addr = waddr_q[ROM_LAT-1];
    assign RAM_in   = ram_in_d;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bmp_copy_engine.sv
// Bench for bmp_copy_engine: one instance with 20-bit addresses and ROM_LAT=1,
// one with 8-bit addresses and ROM_LAT=2, each fed by a synchronous ROM model.
module tb_bmp_copy_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv_a, iv_b;
    logic [19:0] src, dst;
    logic [20:0] len;
    logic [1:0]  mode;

    logic [7:0]  a_rom_out, a_din;
    logic        a_ren, a_ramren, a_wen, a_busy, a_done;
    logic [19:0] a_raddr, a_waddr;
    logic [7:0]  b_rom_out, b_din, b_raddr, b_waddr, b_rom_s0;
    logic        b_ren, b_ramren, b_wen, b_busy, b_done;

    bmp_copy_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(20), .HDR_BYTES(54), .ROM_LAT(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .src_base(src), .dst_base(dst),
        .length(len), .mode(mode), .ROM_out(a_rom_out), .ROM_ren(a_ren),
        .ROM_addr(a_raddr), .RAM_ren(a_ramren), .RAM_wen(a_wen), .RAM_addr(a_waddr),
        .RAM_in(a_din), .busy(a_busy), .done(a_done));

    bmp_copy_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .HDR_BYTES(54), .ROM_LAT(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .src_base(src[7:0]), .dst_base(dst[7:0]),
        .length(len[8:0]), .mode(mode), .ROM_out(b_rom_out), .ROM_ren(b_ren),
        .ROM_addr(b_raddr), .RAM_ren(b_ramren), .RAM_wen(b_wen), .RAM_addr(b_waddr),
        .RAM_in(b_din), .busy(b_busy), .done(b_done));

    // ROM content: ROM[addr] = addr & 0xFF
    always @(posedge clk) begin
        if (a_ren) a_rom_out <= a_raddr[7:0];
        if (b_ren) b_rom_s0 <= b_raddr;
        b_rom_out <= b_rom_s0;
    end

    int          cur_sel;
    logic        m_ren, m_wen, m_busy, m_done, m_ramren;
    logic [19:0] m_raddr, m_waddr;
    logic [7:0]  m_din;

    always_comb begin
        if (cur_sel == 1) begin
            m_ren = b_ren; m_wen = b_wen; m_busy = b_busy; m_done = b_done; m_ramren = b_ramren;
            m_raddr = {12'h0, b_raddr}; m_waddr = {12'h0, b_waddr}; m_din = b_din;
        end else begin
            m_ren = a_ren; m_wen = a_wen; m_busy = a_busy; m_done = a_done; m_ramren = a_ramren;
            m_raddr = a_raddr; m_waddr = a_waddr; m_din = a_din;
        end
    end

    typedef struct {
        int          sel;
        logic [19:0] src;
        logic [19:0] dst;
        int          len;
        logic [1:0]  mode;
        int          inj;
        int          exp_done;
        int          exp_rd0;
        int          exp_w;
    } vec_t;

    vec_t vecs[9];
    int   checks = 0, passed = 0;
    int   n_reads, n_writes, first_w, last_w, done_cyc, first_rd;
    int   rd_err, addr_err, data_err;
    logic post_busy, rst_zero;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    function automatic vec_t mk(int sel, logic [19:0] s, logic [19:0] d, int l, logic [1:0] m,
                                int inj, int ed, int rd0, int w);
        vec_t v;
        v.sel = sel; v.src = s; v.dst = d; v.len = l; v.mode = m;
        v.inj = inj; v.exp_done = ed; v.exp_rd0 = rd0; v.exp_w = w;
        return v;
    endfunction

    function automatic logic [7:0] model_byte(logic [19:0] start, int j, logic [1:0] m, logic [19:0] mask);
        logic [19:0] ra;
        logic [7:0]  v;
        ra = (start + 20'(j)) & mask;
        v  = ra[7:0];
        if (m[0] && (m[1] || j >= 54)) v = ~v;
        return v;
    endfunction

    task automatic set_iv(input int sel, input logic v);
        if (sel == 1) iv_b = v;
        else iv_a = v;
    endtask

    task automatic run_xfer(input int sel, input logic [19:0] s, input logic [19:0] d, input int l,
                            input logic [1:0] m, input int inj, input int rst_at);
        logic [19:0] mask, start;
        int budget;
        mask  = (sel == 1) ? 20'h000FF : 20'hFFFFF;
        start = (m[1] ? s + 20'd54 : s) & mask;
        cur_sel = sel; src = s; dst = d; len = 21'(l); mode = m;
        n_reads = 0; n_writes = 0; first_w = -1; last_w = -1; done_cyc = -1; first_rd = -1;
        rd_err = 0; addr_err = 0; data_err = 0; rst_zero = 1'b0;
        set_iv(sel, 1'b1);
        @(posedge clk);
        budget = (rst_at > 0) ? 60 : l + 12;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            set_iv(sel, n == inj);
            if (rst_at > 0 && n == rst_at + 1) begin
                rst_zero = !(m_ren | m_wen | m_busy | m_done | m_ramren | (|m_raddr) | (|m_waddr) | (|m_din));
                rst = 1'b0;
            end
            if (rst_at > 0 && n == rst_at) rst = 1'b1;
            if (m_ren) begin
                if (n_reads == 0) first_rd = int'(m_raddr);
                if (m_raddr != ((start + 20'(n_reads)) & mask)) rd_err++;
                n_reads++;
            end
            if (m_wen) begin
                if (m_waddr != ((d + 20'(n_writes)) & mask)) addr_err++;
                if (m_din != model_byte(start, n_writes, m, mask)) data_err++;
                if (first_w < 0) first_w = n;
                last_w = n;
                n_writes++;
            end
            if (m_done) begin
                done_cyc = n;
                break;
            end
        end
        @(negedge clk);
        set_iv(sel, 1'b0);
        post_busy = m_busy;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        string t;
        t = $sformatf("v%0d", k);
        run_xfer(v.sel, v.src, v.dst, v.len, v.mode, v.inj, 0);
        chk({t, "_writes"}, n_writes, v.exp_w);
        chk({t, "_reads"}, n_reads, v.exp_w);
        chk({t, "_done_cycle"}, done_cyc, v.exp_done);
        chk({t, "_first_read_addr"}, first_rd, v.exp_rd0);
        chk({t, "_read_addr_errs"}, rd_err, 0);
        chk({t, "_write_addr_errs"}, addr_err, 0);
        chk({t, "_write_data_errs"}, data_err, 0);
        chk({t, "_idle_after_done"}, post_busy, 0);
        if (v.exp_w > 0) begin
            chk({t, "_first_write_cycle"}, first_w, (v.sel == 1) ? 3 : 2);
            chk({t, "_write_span"}, last_w - first_w + 1, v.exp_w);
        end
    endtask

    initial begin
        rst = 1'b1; iv_a = 1'b0; iv_b = 1'b0; cur_sel = 0;
        src = '0; dst = '0; len = '0; mode = '0;

        vecs[0] = mk(0, 20'h00000, 20'h00100, 64, 2'b00, 0, 66, 'h00,    64);
        vecs[1] = mk(1, 20'h00000, 20'h00080, 60, 2'b01, 0, 63, 'h00,    60);
        vecs[2] = mk(0, 20'h00010, 20'h00200,  4, 2'b11, 0,  6, 'h46,     4);
        vecs[3] = mk(1, 20'h000FE, 20'h000FF,  4, 2'b00, 0,  7, 'hFE,     4);
        vecs[4] = mk(0, 20'h00005, 20'h00040,  0, 2'b00, 0,  1, -1,       0);
        vecs[5] = mk(0, 20'h00020, 20'h00300, 10, 2'b00, 3, 12, 'h20,    10);
        vecs[6] = mk(1, 20'h000F0, 20'h00010,  1, 2'b10, 0,  4, 'h26,     1);
        vecs[7] = mk(1, 20'h00030, 20'h00000,  5, 2'b01, 8,  8, 'h30,     5);
        vecs[8] = mk(0, 20'hFFFF0, 20'hFFFFE,  3, 2'b10, 0,  5, 'h26,     3);

        repeat (3) @(negedge clk);
        chk("rst_a_rom_ren", a_ren, 0);
        chk("rst_a_ram_wen", a_wen, 0);
        chk("rst_a_ram_ren", a_ramren, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_rom_addr", a_raddr, 0);
        chk("rst_a_ram_addr", a_waddr, 0);
        chk("rst_a_ram_in", a_din, 0);
        chk("rst_b_busy_wen", {b_busy, b_wen, b_ren, b_done}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 9; k++) run_vec(vecs[k], k);

        // reset asserted during cycle 5 of a 32-byte copy: writes only in cycles 2..5
        run_xfer(0, 20'h00000, 20'h00500, 32, 2'b00, 0, 5);
        chk("rstmid_outputs_zero", rst_zero, 1);
        chk("rstmid_writes", n_writes, 4);
        chk("rstmid_reads", n_reads, 5);
        chk("rstmid_no_done", done_cyc, -1);
        chk("rstmid_data_errs", data_err, 0);

        run_vec(mk(1, 20'h00040, 20'h00060, 8, 2'b11, 0, 11, 'h76, 8), 9);
        run_vec(mk(0, 20'h00100, 20'h00700, 8, 2'b01, 0, 10, 'h100, 8), 10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bmp_copy_engine.md
# bmp_copy_engine

Parametrised ROM-to-RAM byte copy engine for BMP images; the streaming successor to the single-image loader. On a one-cycle `in_valid` request it latches source base, destination base, byte count and mode, then moves one byte per clock through a configurable-latency ROM read pipeline into RAM. It can skip the BMP header and can invert pixel bytes on the fly. It sits between the image ROM and the working RAM, ahead of the processing kernels.

## Interface
- `DATA_WIDTH`, 8: width of one ROM/RAM word (one BMP byte).
- `ADDR_WIDTH`, 20: ROM and RAM address width.
- `HDR_BYTES`, 54: BMP header length in bytes; must be < 2^ADDR_WIDTH.
- `ROM_LAT`, 1: ROM read latency in cycles, from `ROM_ren` to `ROM_out` valid; legal range 1–4.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  start request; sampled only in IDLE.
- `src_base`  in  ADDR_WIDTH  ROM address of image byte 0.
- `dst_base`  in  ADDR_WIDTH  RAM address of first written byte.
- `length`  in  ADDR_WIDTH+1  number of bytes to write; 0 is legal.
- `mode`  in  2  bit0 = invert pixel bytes; bit1 = skip header.
- `ROM_out`  in  DATA_WIDTH  ROM read data.
- `ROM_ren`  out  1  ROM read strobe.
- `ROM_addr`  out  ADDR_WIDTH  ROM read address.
- `RAM_ren`  out  1  constant 0; kept for port compatibility.
- `RAM_wen`  out  1  RAM write strobe.
- `RAM_addr`  out  ADDR_WIDTH  RAM write address.
- `RAM_in`  out  DATA_WIDTH  RAM write data.
- `busy`  out  1  high from the cycle after acceptance through the cycle of `done`.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: when `in_valid`=1, latch `src_base`, `dst_base`, `length` and `mode`.
  - Go to DONE if `length`=0; otherwise go to RUN.
  - `in_valid` is ignored in all other states.
- Read start address: `src_base + HDR_BYTES` if `mode[1]`, else `src_base`. Sum is taken modulo 2^ADDR_WIDTH.
- RUN: one ROM read per cycle (`ROM_ren`=1), incrementing `ROM_addr`, until `length` reads have been issued. Then go to DRAIN.
- A ROM_LAT-deep valid/index shift pipeline tracks in-flight reads.
  - When a read exits the pipeline: `RAM_wen`=1, `RAM_in` = processed `ROM_out`, `RAM_addr` = `dst_base` + write index.
  - Writes occur in both RUN and DRAIN.
- Pixel classification: a byte is a pixel byte if `mode[1]`=1, or if its read index is ≥ HDR_BYTES. Otherwise it is a header byte.
- Processing: if `mode[0]`=1, pixel bytes are written as `~ROM_out` and header bytes pass unchanged. If `mode[0]`=0, all bytes pass unchanged.
- DRAIN: leave when the pipeline is empty (last write done), then go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- Address counters wrap modulo 2^ADDR_WIDTH with no error.
- Read index and write counters are ADDR_WIDTH+1 bits wide, so `length` = 2^ADDR_WIDTH is supported.

## Timing
- Reset values: state IDLE; `ROM_ren`, `RAM_ren`, `RAM_wen`, `busy`, `done` = 0; `ROM_addr`, `RAM_addr`, `RAM_in` = 0; pipeline valids cleared.
- `rst` mid-transfer: in-flight reads are discarded and no further writes occur. Registers take reset values on the next edge.
- Let the accepting edge be cycle 0 and L = `length`.
  - Reads occur in cycles 1..L.
  - Writes occur in cycles 1+ROM_LAT .. L+ROM_LAT.
  - `done` is asserted in cycle L+ROM_LAT+1.
  - For L=0, `done` is asserted in cycle 1 and no strobes are issued.
- Throughput is one byte/cycle, with no bubbles between consecutive writes.
- `in_valid` in the same cycle as `done` is ignored. Next acceptance is possible in the cycle after `done`.
- `ROM_addr` and `RAM_addr` hold their last values when idle.
- `RAM_in` changes only when `RAM_wen`=1.

## Test plan
- Basic copy, ROM_LAT=1: ROM[i]=i&0xFF, src=0, dst=0x100, L=64, mode=0 -> RAM[0x100+i]=i for i<64; exactly 64 `RAM_wen` cycles; `done` in cycle 66.
- Invert with header, ROM_LAT=2: L=60, mode=01 -> bytes 0..53 unchanged, bytes 54..59 inverted (e.g. ROM[54]=0x36 -> RAM 0xC9); `done` in cycle 63.
- Skip header + invert: src=0x10, mode=11, L=4 -> reads at 0x46..0x49; RAM[dst..dst+3] = ~ROM[0x46..0x49].
- L=0 and busy rejection: L=0 -> `done` in cycle 1 with no strobes. Pulse `in_valid` again mid-transfer (L=10) -> ignored; exactly 10 writes.
- Wrap-around, ADDR_WIDTH=8: src=0xFE, dst=0xFF, L=4 -> reads FE, FF, 00, 01; writes FF, 00, 01, 02.
- Reset mid-transfer: assert `rst` at cycle 5 of L=32 -> all outputs 0 next cycle, no further writes. A fresh L=8 request then completes correctly.
